// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the dual-channel (data/instruction) bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned DEFAULT_N_CORES = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_TURN    = 2'd2
  } arb_state_e;

  // Ceiling log2, with a minimum of 1 so that 1-core/1-count widths stay legal.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the cores, the memories and the central bus arbiter.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_CORES = DEFAULT_N_CORES
);
  localparam int unsigned OWNER_W = clog2(N_CORES);

  logic [N_CORES-1:0] D_Bus_RQ;
  logic               D_Bus_Ready;
  logic [N_CORES-1:0] D_Bus_GRANT;
  logic [OWNER_W-1:0] D_Owner;
  logic               D_Timeout;

  logic [N_CORES-1:0] I_Bus_RQ;
  logic               I_Bus_Ready;
  logic [N_CORES-1:0] I_Bus_GRANT;
  logic [OWNER_W-1:0] I_Owner;
  logic               I_Timeout;

  // Arbiter side
  modport master (
    input  D_Bus_RQ, D_Bus_Ready, I_Bus_RQ, I_Bus_Ready,
    output D_Bus_GRANT, D_Owner, D_Timeout, I_Bus_GRANT, I_Owner, I_Timeout
  );

  // Requester / memory side
  modport slave (
    output D_Bus_RQ, D_Bus_Ready, I_Bus_RQ, I_Bus_Ready,
    input  D_Bus_GRANT, D_Owner, D_Timeout, I_Bus_GRANT, I_Owner, I_Timeout
  );

endinterface

// File: rtl/rr_arb_channel.sv
// One bus worth of round-robin arbitration: grant FSM, rotating pointer and
// Ready watchdog. A single dead TURN cycle separates every release from the next grant.
module rr_arb_channel
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_CORES = DEFAULT_N_CORES,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_CORES-1:0]          rq,
  input  logic                        ready,
  output logic [N_CORES-1:0]          grant,
  output logic [clog2(N_CORES)-1:0]   owner,
  output logic                        timeout
);
  localparam int unsigned OWNER_W = clog2(N_CORES);

  arb_state_e         state_q, state_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [N_CORES-1:0] grant_q, grant_d;
  logic               timeout_q, timeout_d;
  logic [OWNER_W-1:0] winner;
  logic [OWNER_W-1:0] owner_next;
  logic               found;
  int unsigned        idx;
  logic               expire;
  logic               cnt_clr;
  logic               cnt_inc;

  // First requester at or above the pointer, wrapping modulo N_CORES.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_CORES) idx = idx - N_CORES;
      if (!found && rq[OWNER_W'(idx)]) begin
        winner = OWNER_W'(idx);
        found  = 1'b1;
      end
    end
  end

  assign owner_next = (owner_q == OWNER_W'(N_CORES - 1)) ? '0 : owner_q + OWNER_W'(1);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      ARB_IDLE, ARB_TURN: begin
        grant_d = '0;
        state_d = ARB_IDLE;
        if (|rq) begin
          state_d = ARB_GRANTED;
          grant_d = N_CORES'(1) << winner;
          owner_d = winner;
          cnt_clr = 1'b1;
        end
      end
      ARB_GRANTED: begin
        // Withdrawal beats Ready beats watchdog; only the watchdog flags a timeout.
        if (!rq[owner_q] || ready) begin
          state_d = ARB_TURN;
          grant_d = '0;
          ptr_d   = owner_next;
        end else if (expire) begin
          state_d   = ARB_TURN;
          grant_d   = '0;
          ptr_d     = owner_next;
          timeout_d = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  // Watchdog counts grant cycles spent waiting for Ready.
  if (TIMEOUT != 0) begin : g_wdog
    localparam int unsigned CNT_W = clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign expire = (cnt_q == CNT_W'(TIMEOUT - 1));
  end else begin : g_no_wdog
    assign expire = 1'b0;
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared data and instruction buses: two independent
// round-robin channels, wiring only.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_CORES = DEFAULT_N_CORES,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clock,
  input  logic          reset_n,
  bus_arbiter_if.master bus
);

  rr_arb_channel #(
    .N_CORES (N_CORES),
    .TIMEOUT (TIMEOUT)
  ) u_d_chan (
    .clock   (clock),
    .reset_n (reset_n),
    .rq      (bus.D_Bus_RQ),
    .ready   (bus.D_Bus_Ready),
    .grant   (bus.D_Bus_GRANT),
    .owner   (bus.D_Owner),
    .timeout (bus.D_Timeout)
  );

  rr_arb_channel #(
    .N_CORES (N_CORES),
    .TIMEOUT (TIMEOUT)
  ) u_i_chan (
    .clock   (clock),
    .reset_n (reset_n),
    .rq      (bus.I_Bus_RQ),
    .ready   (bus.I_Bus_Ready),
    .grant   (bus.I_Bus_GRANT),
    .owner   (bus.I_Owner),
    .timeout (bus.I_Timeout)
  );

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter for the shared Data and Instruction buses of the multicore MIPS32 system.
- Receives one D_Bus_RQ and one I_Bus_RQ from each per-core arbitration submodule.
- Returns one-hot D_Bus_GRANT / I_Bus_GRANT vectors. The two buses are arbitrated by two independent round-robin channels.
- A grant is held until the memory signals Ready, the requester withdraws, or a watchdog expires. One idle turnaround cycle follows every release so that only one core's tri-state drivers are ever on a bus.

Parameters:
- N_CORES, 4, number of requesting cores (2..16).
- TIMEOUT, 255, max cycles a grant may wait for Ready before forced release; 0 disables the watchdog.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- D_Bus_RQ  in  N_CORES  data-bus request, bit i from core i.
- D_Bus_Ready  in  1  data memory Ready, as seen on the shared bus.
- D_Bus_GRANT  out  N_CORES  one-hot (or zero) data-bus grant.
- D_Owner  out  clog2(N_CORES)  index of current/last data-bus owner.
- D_Timeout  out  1  one-cycle pulse on data-bus watchdog release.
- I_Bus_RQ  in  N_CORES  instruction-bus request.
- I_Bus_Ready  in  1  instruction memory Ready.
- I_Bus_GRANT  out  N_CORES  one-hot (or zero) instruction-bus grant.
- I_Owner  out  clog2(N_CORES)  index of current/last instruction-bus owner.
- I_Timeout  out  1  one-cycle pulse on instruction-bus watchdog release.

Behaviour:
- Both channels are identical and fully independent; there is no interaction between them. All outputs are registered.
- Reset (async, reset_n=0): GRANT=0, Owner=0, Timeout=0, state=IDLE, rr pointer=0, watchdog counter=0. Reset mid-grant drops GRANT immediately (asynchronously).
- States per channel: IDLE, GRANTED, TURN.
- IDLE:
  - If RQ!=0 at a clock edge: winner = first set bit scanning from ptr upward, modulo N_CORES.
  - GRANT[winner]=1 and Owner=winner from the next cycle; go to GRANTED.
  - Latency is 1 cycle from RQ high to GRANT high.
  - If RQ=0: stay in IDLE.
- GRANTED, evaluated each edge with priority top-down:
  - (a) RQ[Owner]=0 (requester withdrew) -> TURN.
  - (b) Ready=1 -> TURN.
  - (c) TIMEOUT!=0 and counter==TIMEOUT-1 -> TURN, with a Timeout pulse high for exactly the next cycle.
  - Otherwise stay in GRANTED and counter+1.
  - The counter clears on entry to GRANTED.
  - Other cores' requests are ignored while GRANTED; there is no preemption.
- TURN:
  - GRANT=0 for exactly one cycle and ptr = (Owner+1) mod N_CORES.
  - Then go to IDLE; arbitration happens at that edge.
  - Back-to-back transfers by different cores are therefore spaced by 1 dead cycle. Grant-to-grant spacing is at minimum 2 cycles after the Ready edge.
- Owner holds its value through TURN and IDLE (it shows the last owner).
- GRANT is never multi-hot, by construction. Any bit of GRANT set implies state=GRANTED.
- Ready while in IDLE or TURN is ignored.
- Ready and withdrawal in the same cycle resolve to a single TURN, with no Timeout pulse.
- A request that remains high after its Ready is re-arbitrated as a fresh request. It loses to any other pending core because of the pointer rotation.
- Fairness: with all cores requesting continuously, grants go 0,1,2,...,N_CORES-1,0,...
- The watchdog counter width is clog2(TIMEOUT+1). When TIMEOUT=0 the counter is not instantiated.

Decomposition:
- Package bus_arbiter_pkg holds:
  - the state encoding (ARB_IDLE=2'd0, ARB_GRANTED=2'd1, ARB_TURN=2'd2);
  - a clog2 function;
  - the default N_CORES/TIMEOUT constants.
- Sub-module rr_arb_channel holds one bus worth of FSM, pointer, watchdog and round-robin priority select. bus_arbiter instantiates it twice (data, instruction) and contains only wiring.

Test Plan:
- Reset: hold reset_n=0 with all RQ=4'b1111 -> GRANT=0, Owner=0, Timeout=0. Release reset -> D_Bus_GRANT=4'b0001 one cycle later.
- Single transfer: D_Bus_RQ=4'b0100 at cycle 0; Ready at cycle 3 -> GRANT=4'b0100 in cycles 1-3, 0 in cycle 4, D_Owner=2 throughout.
- Round robin: all RQ=4'b1111, Ready pulsed each time a grant is seen -> grant order 0,1,2,3,0, with exactly one zero-grant cycle between consecutive grants.
- Independence: D_Bus_RQ=4'b0010 and I_Bus_RQ=4'b1000 in the same cycle -> D_Bus_GRANT=4'b0010 and I_Bus_GRANT=4'b1000 both in the next cycle.
- Watchdog: TIMEOUT=8, I_Bus_RQ=4'b0001, I_Bus_Ready held 0 -> grant lasts 8 cycles, I_Timeout pulses once (1 cycle), then a TURN cycle, then re-grant to core 0 if it is still requesting.
- Withdrawal and reset: core 1 drops RQ mid-grant -> GRANT=0 next cycle. Assert reset_n=0 mid-grant -> GRANT=0 immediately, with no clock edge required.
